// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller with memory handshake.
// Covers states, opcode/funct values, ALU/PC select codes, cause codes and decode helpers.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EXE, S_WB, S_MADR, S_MRD, S_MWR, S_LWB, S_BR, S_LINK, S_JMP, S_EXC
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL  = 6'h03, OP_BEQ   = 6'h04,
                         OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI  = 6'h0C, OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA = 6'h03, FN_JR  = 6'h08,
                         FN_JALR = 6'h09, FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22,
                         FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR  = 6'h25, FN_XOR = 6'h26,
                         FN_NOR  = 6'h27, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_FUNCT = 3'b010,
                         ALU_AND = 3'b100, ALU_SLT = 3'b101;

  localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10, PC_EXC = 2'b11;

  localparam int unsigned CAUSE_INT = 0, CAUSE_BUS = 7, CAUSE_ILL = 10;

  function automatic logic is_shift(input logic [5:0] fn);
    return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
  endfunction

  // Decode-stage dispatch; anything not recognised becomes an illegal-instruction exception.
  function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] fn);
    state_t nxt;
    nxt = S_EXC;
    case (op)
      OP_LW, OP_SW: nxt = S_MADR;
      OP_RTYPE: begin
        case (fn)
          FN_JR:   nxt = S_JMP;
          FN_JALR: nxt = S_LINK;
          FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: nxt = S_EXE;
          default: nxt = S_EXC;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU, OP_LUI: nxt = S_EXE;
      OP_BEQ:  nxt = S_BR;
      OP_J:    nxt = S_JMP;
      OP_JAL:  nxt = S_LINK;
      default: nxt = S_EXC;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_ctrl_hs_if.sv
// Variable-latency memory handshake between the controller (master) and memory (slave).
interface mc_ctrl_hs_if;
  logic mem_req;
  logic mem_ready;

  modport master (output mem_req, input mem_ready);
  modport slave  (input mem_req, output mem_ready);
endinterface

// File: rtl/mc_wait_timer.sv
// Per-access wait counter; flags a bus timeout once MEM_TIMEOUT idle wait cycles have elapsed.
module mc_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_wait,
  output logic o_timeout_c
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  assign o_timeout_c = (MEM_TIMEOUT != 0) && i_wait && (r_cnt == LIMIT);

  // Every exit from a memory state follows ready or timeout, so clearing on those covers state entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     r_cnt <= '0;
    else if (!i_wait || o_timeout_c) r_cnt <= '0;
    else if (r_cnt != '1)          r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multi-cycle MIPS control FSM with memory handshake, bus timeout, precise exceptions and interrupts.
module mc_ctrl_hs
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned IRQ_ENABLE  = 1,
  parameter int unsigned CAUSE_W     = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  mc_ctrl_hs_if.master       bus,
  input  logic               irq,
  input  logic               int_en,
  output logic               PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
  output logic               IRWrite, RegWrite, ExtOp, LuiOp,
  output logic [1:0]         MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource,
  output logic [3:0]         ALUOp,
  output logic               EPCWrite, CauseWrite,
  output logic [CAUSE_W-1:0] cause,
  output logic               busy
);

  state_t               r_state;
  logic [CAUSE_W-1:0]   r_cause;
  state_t               w_dispatch;
  logic                 w_mem_state, w_timeout, w_irq_take, w_rtype, w_mem_req;

  assign w_dispatch  = dispatch(opcode, funct);
  assign w_mem_state = (r_state == S_IF) || (r_state == S_MRD) || (r_state == S_MWR);
  assign w_irq_take  = (IRQ_ENABLE != 0) && irq && int_en;
  assign w_rtype     = (opcode == OP_RTYPE);
  assign bus.mem_req = w_mem_req;

  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk         (clk),
    .reset       (reset),
    .i_wait      (w_mem_state && !bus.mem_ready),
    .o_timeout_c (w_timeout)
  );

  // State and latched exception cause; ready beats timeout, timeout beats irq.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IF;
      r_cause <= '0;
    end else begin
      unique case (r_state)
        S_IF, S_MRD, S_MWR: begin
          if (bus.mem_ready) begin
            if (r_state == S_IF)       r_state <= S_ID;
            else if (r_state == S_MRD) r_state <= S_LWB;
            else if (w_irq_take) begin
              r_state <= S_EXC;
              r_cause <= CAUSE_W'(CAUSE_INT);
            end else                   r_state <= S_IF;
          end else if (w_timeout) begin
            r_state <= S_EXC;
            r_cause <= CAUSE_W'(CAUSE_BUS);
          end
        end
        S_ID: begin
          r_state <= w_dispatch;
          if (w_dispatch == S_EXC) r_cause <= CAUSE_W'(CAUSE_ILL);
        end
        S_EXE:  r_state <= S_WB;
        S_MADR: r_state <= (opcode == OP_LW) ? S_MRD : S_MWR;
        S_LINK: r_state <= S_JMP;
        S_WB, S_LWB, S_BR, S_JMP: begin
          if (w_irq_take) begin
            r_state <= S_EXC;
            r_cause <= CAUSE_W'(CAUSE_INT);
          end else r_state <= S_IF;
        end
        default: r_state <= S_IF;
      endcase
    end
  end

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    w_mem_req = 1'b0; PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0; MemRead = 1'b0;
    MemWrite = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0; ExtOp = 1'b0; LuiOp = 1'b0;
    MemtoReg = 2'b00; RegDst = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b00; PCSource = PC_ALU;
    ALUOp = 4'b0000; EPCWrite = 1'b0; CauseWrite = 1'b0; cause = '0; busy = 1'b0;
    if (!reset) begin
      ALUOp = {opcode[0], ALU_ADD};
      busy  = (r_state != S_IF);
      unique case (r_state)
        S_IF: begin
          w_mem_req = 1'b1; MemRead = 1'b1; ALUSrcB = 2'b01; PCSource = PC_ALU;
          IRWrite   = bus.mem_ready;
          PCWrite   = bus.mem_ready;
        end
        S_ID: ALUSrcB = 2'b11;
        S_EXE: begin
          ALUSrcA = (w_rtype && is_shift(funct)) ? 2'b10 : 2'b01;
          ALUSrcB = w_rtype ? 2'b00 : 2'b10;
          ExtOp   = (opcode == OP_ADDI) || (opcode == OP_ANDI) ||
                    (opcode == OP_SLTI) || (opcode == OP_LUI);
          LuiOp   = (opcode == OP_LUI);
          if (w_rtype)                                          ALUOp[2:0] = ALU_FUNCT;
          else if (opcode == OP_ANDI)                           ALUOp[2:0] = ALU_AND;
          else if ((opcode == OP_SLTI) || (opcode == OP_SLTIU)) ALUOp[2:0] = ALU_SLT;
        end
        S_WB: begin
          RegWrite = 1'b1; MemtoReg = 2'b01;
          RegDst   = w_rtype ? 2'b01 : 2'b00;
        end
        S_MADR: begin
          ALUSrcA = 2'b01; ALUSrcB = 2'b10; ExtOp = 1'b1;
        end
        S_MRD: begin
          w_mem_req = 1'b1; IorD = 1'b1; MemRead = 1'b1;
        end
        S_MWR: begin
          w_mem_req = 1'b1; IorD = 1'b1; MemWrite = 1'b1;
        end
        S_LWB: RegWrite = 1'b1;
        S_BR: begin
          PCWriteCond = 1'b1; ALUSrcA = 2'b01; PCSource = PC_ALUOUT; ALUOp[2:0] = ALU_SUB;
        end
        S_LINK: begin
          RegWrite = 1'b1; MemtoReg = 2'b10;
          RegDst   = (opcode == OP_JAL) ? 2'b10 : 2'b01;
        end
        S_JMP: begin
          PCWrite = 1'b1; PCSource = PC_JUMP;
        end
        S_EXC: begin
          EPCWrite = 1'b1; CauseWrite = 1'b1; PCWrite = 1'b1; PCSource = PC_EXC;
          cause    = r_cause;
        end
        default: busy = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Directed bench for mc_ctrl_hs: every control output is compared as one packed vector per step.
module tb_mc_ctrl_hs;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, rw, ext, lui;
    logic [1:0] m2r, rdst, srca, srcb, pcs;
    logic [3:0] aluop;
    logic       epcw, causew;
    logic [4:0] cause;
    logic       req, busy;
  } ctl_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode, funct;
  logic irq, int_en;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp;
  logic [1:0] MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource;
  logic [3:0] ALUOp;
  logic EPCWrite, CauseWrite, busy;
  logic [4:0] cause;
  ctl_t obs;
  int n_asrt = 0;
  int n_fail = 0;
  int n_req, n_irw;

  mc_ctrl_hs_if bus ();

  mc_ctrl_hs dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .bus(bus),
    .irq(irq), .int_en(int_en),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ExtOp(ExtOp), .LuiOp(LuiOp),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUOp(ALUOp), .EPCWrite(EPCWrite), .CauseWrite(CauseWrite),
    .cause(cause), .busy(busy)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp,
                MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, EPCWrite, CauseWrite,
                cause, bus.mem_req, busy};

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input ctl_t e);
    n_asrt++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic chk(input string tag, input int o, input int e);
    n_asrt++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // Zero-wait fetch: checks the S_IF ready cycle and leaves the FSM in S_ID.
  task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input string tag);
    opcode = op; funct = fn; bus.mem_ready = 1'b1;
    #1;
    chk_ctl({tag, "_if"}, ctl_t'{pcw: 1'b1, mrd: 1'b1, irw: 1'b1, srcb: 2'b01,
                                aluop: {op[0], 3'b000}, req: 1'b1, default: '0});
    cyc();
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    opcode = 6'h00; funct = 6'h20; irq = 1'b0; int_en = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_ctl("reset_all_low", '0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_ctl("if_after_reset", ctl_t'{mrd: 1'b1, srcb: 2'b01, req: 1'b1, default: '0});

    // Zero-wait add
    fetch(6'h00, 6'h20, "add");
    chk_ctl("add_id", ctl_t'{srcb: 2'b11, busy: 1'b1, default: '0});
    cyc(); chk_ctl("add_exe", ctl_t'{srca: 2'b01, aluop: 4'b0010, busy: 1'b1, default: '0});
    cyc(); chk_ctl("add_wb", ctl_t'{rw: 1'b1, m2r: 2'b01, rdst: 2'b01, busy: 1'b1, default: '0});
    cyc(); chk_ctl("add_if", ctl_t'{mrd: 1'b1, srcb: 2'b01, req: 1'b1, default: '0});

    // lw with three wait cycles in fetch and in the read
    opcode = 6'h23; funct = 6'h00; n_req = 0; n_irw = 0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i == 3); #1;
      n_req += int'(bus.mem_req); n_irw += int'(IRWrite);
      cyc();
    end
    bus.mem_ready = 1'b0;
    chk("lw_if_req_cycles", n_req, 4);
    chk("lw_irw_pulses", n_irw, 1);
    chk_ctl("lw_id", ctl_t'{srcb: 2'b11, aluop: 4'b1000, busy: 1'b1, default: '0});
    cyc(); chk_ctl("lw_madr", ctl_t'{srca: 2'b01, srcb: 2'b10, ext: 1'b1, aluop: 4'b1000,
                                    busy: 1'b1, default: '0});
    cyc(); chk_ctl("lw_mrd", ctl_t'{iord: 1'b1, mrd: 1'b1, aluop: 4'b1000, req: 1'b1,
                                   busy: 1'b1, default: '0});
    n_req = 0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i == 3); #1;
      n_req += int'(bus.mem_req);
      cyc();
    end
    bus.mem_ready = 1'b0;
    chk("lw_mrd_req_cycles", n_req, 4);
    chk_ctl("lw_lwb", ctl_t'{rw: 1'b1, aluop: 4'b1000, busy: 1'b1, default: '0});
    cyc(); chk_ctl("lw_if", ctl_t'{mrd: 1'b1, srcb: 2'b01, aluop: 4'b1000, req: 1'b1, default: '0});

    // Ready arriving on the timeout cycle completes the fetch
    opcode = 6'h00; funct = 6'h20;
    for (int i = 0; i < 16; i++) begin
      bus.mem_ready = (i == 15); #1;
      cyc();
    end
    bus.mem_ready = 1'b0;
    chk_ctl("ready_wins_id", ctl_t'{srcb: 2'b11, busy: 1'b1, default: '0});
    repeat (3) cyc();

    // sw with memory never ready: bus timeout
    fetch(6'h2B, 6'h00, "sw");
    cyc(); cyc();
    chk_ctl("sw_mwr", ctl_t'{iord: 1'b1, mwr: 1'b1, aluop: 4'b1000, req: 1'b1,
                            busy: 1'b1, default: '0});
    n_req = 0;
    while (bus.mem_req && n_req < 40) begin
      n_req++;
      cyc();
    end
    chk("sw_mwr_req_cycles", n_req, 16);
    chk_ctl("sw_exc", ctl_t'{pcw: 1'b1, pcs: 2'b11, aluop: 4'b1000, epcw: 1'b1, causew: 1'b1,
                            cause: 5'd7, busy: 1'b1, default: '0});
    cyc(); chk_ctl("sw_if", ctl_t'{mrd: 1'b1, srcb: 2'b01, aluop: 4'b1000, req: 1'b1, default: '0});

    // Illegal opcode and illegal funct
    fetch(6'h3F, 6'h00, "ill_op");
    chk_ctl("ill_op_id", ctl_t'{srcb: 2'b11, aluop: 4'b1000, busy: 1'b1, default: '0});
    cyc(); chk_ctl("ill_op_exc", ctl_t'{pcw: 1'b1, pcs: 2'b11, aluop: 4'b1000, epcw: 1'b1,
                                       causew: 1'b1, cause: 5'd10, busy: 1'b1, default: '0});
    cyc(); chk_ctl("ill_op_if", ctl_t'{mrd: 1'b1, srcb: 2'b01, aluop: 4'b1000, req: 1'b1, default: '0});
    fetch(6'h00, 6'h3F, "ill_fn");
    cyc(); chk_ctl("ill_fn_exc", ctl_t'{pcw: 1'b1, pcs: 2'b11, epcw: 1'b1, causew: 1'b1,
                                       cause: 5'd10, busy: 1'b1, default: '0});
    cyc();

    // beq with interrupt enabled, then masked
    irq = 1'b1; int_en = 1'b1;
    fetch(6'h04, 6'h00, "beq_irq");
    cyc(); chk_ctl("beq_br", ctl_t'{pcwc: 1'b1, srca: 2'b01, pcs: 2'b01, aluop: 4'b0001,
                                   busy: 1'b1, default: '0});
    cyc(); chk_ctl("beq_irq_exc", ctl_t'{pcw: 1'b1, pcs: 2'b11, epcw: 1'b1, causew: 1'b1,
                                        cause: 5'd0, busy: 1'b1, default: '0});
    cyc(); chk_ctl("beq_irq_if", ctl_t'{mrd: 1'b1, srcb: 2'b01, req: 1'b1, default: '0});
    int_en = 1'b0;
    fetch(6'h04, 6'h00, "beq_mask");
    cyc(); cyc();
    chk_ctl("beq_mask_if", ctl_t'{mrd: 1'b1, srcb: 2'b01, req: 1'b1, default: '0});
    irq = 1'b0;

    // andi and sll execute selects
    fetch(6'h0C, 6'h00, "andi");
    cyc(); chk_ctl("andi_exe", ctl_t'{srca: 2'b01, srcb: 2'b10, ext: 1'b1, aluop: 4'b0100,
                                     busy: 1'b1, default: '0});
    cyc(); chk_ctl("andi_wb", ctl_t'{rw: 1'b1, m2r: 2'b01, busy: 1'b1, default: '0});
    cyc();
    fetch(6'h00, 6'h00, "sll");
    cyc(); chk_ctl("sll_exe", ctl_t'{srca: 2'b10, aluop: 4'b0010, busy: 1'b1, default: '0});
    cyc(); cyc();

    // jal and jalr link paths
    fetch(6'h03, 6'h00, "jal");
    cyc(); chk_ctl("jal_link", ctl_t'{rw: 1'b1, m2r: 2'b10, rdst: 2'b10, aluop: 4'b1000,
                                     busy: 1'b1, default: '0});
    cyc(); chk_ctl("jal_jmp", ctl_t'{pcw: 1'b1, pcs: 2'b10, aluop: 4'b1000, busy: 1'b1, default: '0});
    cyc(); chk_ctl("jal_if", ctl_t'{mrd: 1'b1, srcb: 2'b01, aluop: 4'b1000, req: 1'b1, default: '0});
    fetch(6'h00, 6'h09, "jalr");
    cyc(); chk_ctl("jalr_link", ctl_t'{rw: 1'b1, m2r: 2'b10, rdst: 2'b01, busy: 1'b1, default: '0});
    cyc(); cyc();

    // Reset asserted in S_LINK
    fetch(6'h03, 6'h00, "jal_rst");
    cyc();
    reset = 1'b1; #1;
    chk_ctl("reset_in_link", '0);
    @(negedge clk);
    reset = 1'b0; #1;
    chk_ctl("if_after_rst", ctl_t'{mrd: 1'b1, srcb: 2'b01, aluop: 4'b1000, req: 1'b1, default: '0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
